// File: rtl/xgemac_pkg.sv
// Shared XGEMAC TX types: beat widths, beat struct and the arbiter state encoding.
package xgemac_pkg;

    localparam int XGEMAC_DATA_WIDTH = 64;
    localparam int XGEMAC_MOD_WIDTH  = 3;

    // mod == 0 on an eop beat means all bytes valid
    typedef struct packed {
        logic [XGEMAC_DATA_WIDTH-1:0] data;
        logic                         sop;
        logic                         eop;
        logic [XGEMAC_MOD_WIDTH-1:0]  mod;
    } xgemac_beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/xgemac_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, on a tie the port other than last wins.
module xgemac_rr_pick
    import xgemac_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       valid
);

    always_comb begin
        valid = |req;
        gnt   = 1'b0;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/xgemac_tx_arbiter.sv
// Packet-atomic two-port round-robin arbiter in front of the XGEMAC pkt_tx interface.
// Optional statistics counters are enabled with `define XGEMAC_TX_ARB_STATS_EN.
module xgemac_tx_arbiter
    import xgemac_pkg::*;
#(
    parameter int DATA_WIDTH = XGEMAC_DATA_WIDTH,
    parameter int MOD_WIDTH  = XGEMAC_MOD_WIDTH,
    parameter int MAX_BEATS  = 200
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0][DATA_WIDTH-1:0] src_data,
    input  logic [1:0]                 src_val,
    input  logic [1:0]                 src_sop,
    input  logic [1:0]                 src_eop,
    input  logic [1:0][MOD_WIDTH-1:0]  src_mod,
    output logic [1:0]                 src_rdy,
    output logic [DATA_WIDTH-1:0]      pkt_tx_data,
    output logic                       pkt_tx_val,
    output logic                       pkt_tx_sop,
    output logic                       pkt_tx_eop,
    output logic [MOD_WIDTH-1:0]       pkt_tx_mod,
    input  logic                       pkt_tx_full,
    output logic                       arb_err
`ifdef XGEMAC_TX_ARB_STATS_EN
    ,
    output logic [1:0][31:0]           pkt_cnt,
    output logic [15:0]                err_cnt
`endif
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    arb_state_e       state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    xgemac_beat_t     out_q, out_d;
    logic             val_q, val_d;
    logic             err_q, err_d;
    logic [1:0]       idle_err_q, idle_err_d;

    logic             pick_gnt, pick_vld;
    logic [1:0]       bad;
    logic             acc, sop_err, wdog;
    xgemac_beat_t     sel;

    assign bad = src_val & ~src_sop;

    xgemac_rr_pick u_pick (
        .req   (src_val & src_sop),
        .last  (last_q),
        .gnt   (pick_gnt),
        .valid (pick_vld)
    );

    always_comb begin
        src_rdy = '0;
        if (state_q == XFER && !pkt_tx_full) src_rdy[grant_q] = 1'b1;
    end

    always_comb begin
        sel.data = src_data[grant_q];
        sel.sop  = src_sop[grant_q];
        sel.eop  = src_eop[grant_q];
        sel.mod  = src_mod[grant_q];
    end

    assign acc = src_val[grant_q] & src_rdy[grant_q];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        out_d      = '0;
        val_d      = 1'b0;
        err_d      = 1'b0;
        idle_err_d = idle_err_q;
        sop_err    = 1'b0;
        wdog       = 1'b0;
        case (state_q)
            IDLE: begin
                // A stuck sop-less beat raises arb_err once, not every idle cycle
                idle_err_d = bad;
                err_d      = |(bad & ~idle_err_q);
                cnt_d      = '0;
                if (pick_vld) begin
                    grant_d = pick_gnt;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (acc) begin
                    sop_err    = sel.sop && (cnt_q != '0);
                    wdog       = !sel.eop && (cnt_q == CNT_W'(MAX_BEATS - 1));
                    val_d      = 1'b1;
                    out_d.data = sel.data;
                    out_d.sop  = sel.sop && !sop_err;
                    out_d.eop  = sel.eop || wdog;
                    out_d.mod  = sel.eop ? sel.mod : '0;
                    err_d      = sop_err || wdog;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (out_d.eop) begin
                        last_d  = grant_q;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            out_q      <= '0;
            val_q      <= 1'b0;
            err_q      <= 1'b0;
            idle_err_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            val_q      <= val_d;
            err_q      <= err_d;
            idle_err_q <= idle_err_d;
        end
    end

    assign pkt_tx_data = out_q.data;
    assign pkt_tx_val  = val_q;
    assign pkt_tx_sop  = out_q.sop;
    assign pkt_tx_eop  = out_q.eop;
    assign pkt_tx_mod  = out_q.mod;
    assign arb_err     = err_q;

`ifdef XGEMAC_TX_ARB_STATS_EN
    logic [1:0][31:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;

    // Counted on the decision cycle so counters change with the outputs they describe
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        if (val_d && out_d.eop) pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + 32'd1;
        if (err_d && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/xgemac_tx_arbiter.md
Name: xgemac_tx_arbiter

Overview:
- Two-requester, packet-atomic round-robin arbiter sharing the single XGEMAC TX packet interface (pkt_tx_*).
- Sits between two packet sources (for example a frame generator and a pause/control source) and the MAC.
- Honours pkt_tx_full backpressure.
- Never interleaves beats of different packets.

Parameters:
- DATA_WIDTH, 64, beat width; equals `XGEMAC_TXRX_DATA_WIDTH.
- MOD_WIDTH, 3, byte-valid modulo width; equals `XGEMAC_TXRX_MOD_WIDTH.
- MAX_BEATS, 200, watchdog limit on beats per packet (jumbo frame plus margin).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- src_data[0:1]  in  2xDATA_WIDTH  requester beat data.
- src_val[0:1]  in  2x1  requester beat valid.
- src_sop[0:1]  in  2x1  requester start of packet.
- src_eop[0:1]  in  2x1  requester end of packet.
- src_mod[0:1]  in  2xMOD_WIDTH  requester valid bytes on the eop beat (0 means all 8).
- src_rdy[0:1]  out  2x1  beat accepted this cycle when src_val and src_rdy are both 1.
- pkt_tx_data  out  DATA_WIDTH  to MAC.
- pkt_tx_val  out  1  to MAC.
- pkt_tx_sop  out  1  to MAC.
- pkt_tx_eop  out  1  to MAC.
- pkt_tx_mod  out  MOD_WIDTH  to MAC.
- pkt_tx_full  in  1  MAC FIFO full; no new beat may be issued while it is high.
- arb_err  out  1  one-cycle pulse on a protocol error or watchdog abort.

Behaviour:
- Reset: all pkt_tx_* outputs are 0, src_rdy is 0, arb_err is 0, state is IDLE, last_grant is 1 (so port 0 wins first), beat counter is 0.
- Outputs are registered. A beat accepted in cycle N appears on pkt_tx_* in cycle N+1. pkt_tx_val is 1 for exactly one cycle per accepted beat.
- src_rdy[i] = (state==XFER) & (grant==i) & !pkt_tx_full. It is combinational from the state register and pkt_tx_full. src_rdy is always 0 in IDLE.
- In IDLE, a port is requesting when src_val[i] and src_sop[i] are both 1.
  - If both ports request, the winner is the port other than last_grant.
  - If one port requests, it wins.
  - The winner is latched into grant and the state moves to XFER. This costs 1 idle cycle per packet.
  - No beat is consumed in IDLE.
- In XFER, a beat is accepted when src_val[grant] and src_rdy[grant] are both 1. The accepted beat is forwarded and the beat counter increments.
  - An accepted beat with eop=1 sets last_grant=grant and returns the state to IDLE.
  - A single-beat packet (sop and eop on the same beat) is legal.
- pkt_tx_mod is forwarded only on eop beats and is forced to 0 on all other beats.
- Protocol errors:
  - In IDLE, src_val=1 with sop=0 on a port: that beat is not consumed and is never acknowledged. arb_err pulses once on entry to the error condition.
  - In XFER, an accepted beat with sop=1 and a beat count above 0: the beat is forwarded with sop forced to 0 and arb_err pulses.
- Watchdog: if the beat count reaches MAX_BEATS without an eop, the arbiter does the following in one cycle:
  - it emits one forced beat with eop=1 and mod=0;
  - it pulses arb_err;
  - it returns to IDLE.
  - The source's remaining beats then fall under the IDLE error rule.
- pkt_tx_full high in XFER: src_rdy drops in the same cycle and pkt_tx_val is 0 in the next cycle. The state is held and transfer resumes when full drops.
- A beat already registered when full rises is still presented. The MAC's full threshold absorbs this 1-beat skid.
- pkt_tx_full has no effect on arbitration decisions made in IDLE.
- Reset asserted mid-packet returns the block to the reset state in the next cycle. No eop is generated for the truncated packet.

Optional Feature:
- Macro XGEMAC_TX_ARB_STATS_EN.
- When defined, the block adds these outputs:
  - pkt_cnt[0:1], 32 bits each: increments on each forwarded eop from that port, wraps at 2^32.
  - err_cnt, 16 bits: saturates at 0xFFFF and increments on every arb_err pulse.
  - All counters clear on rst.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package xgemac_pkg holds:
  - the DATA_WIDTH and MOD_WIDTH constants;
  - typedef xgemac_beat_t, a struct of data, sop, eop and mod;
  - an enum arb_state_e {IDLE, XFER}.
- Natural sub-module: xgemac_rr_pick, a 2-way round-robin picker (req[1:0], last -> gnt, valid).

Test Plan:
- Port 0 only, 4-beat packet with eop mod=3 -> pkt_tx_* shows 4 consecutive beats with sop on beat 1, eop with mod=3 on beat 4; first beat appears 2 cycles after src_val rises.
- Both ports request continuously with 3-beat packets -> order P0, P1, P0, P1; no beats interleaved; 1 idle cycle between packets.
- pkt_tx_full held high for 5 cycles mid-packet -> src_rdy is 0 for 5 cycles; pkt_tx_val is 0 for 5 cycles after a 1-cycle skid; no beat lost or duplicated; data matches the scoreboard.
- Single-beat packet with sop=eop=1 and mod=0 on port 1 -> one output beat with sop=eop=1; state back to IDLE on the next cycle.
- Port 0 sends 201 beats without eop (MAX_BEATS=200) -> forced eop with mod=0 on beat 200; arb_err pulses; port 1 is then granted.
- rst pulsed on beat 2 of a 5-beat packet -> all outputs 0 the next cycle; the next packet starts cleanly from port 0.
